// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected capture of {frame_err, data}, level/irq/overrun status.
// Optional idle timeout when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_new_data,
  input  logic                  rx_frame_err,
  input  logic                  flush,
  input  logic                  rd_en,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  input  logic [23:0]           timeout_cycles,
  output logic                  timeout,
`endif
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_frame_err,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic [DEPTH_LOG2:0]   irq_thresh,
  output logic                  irq_level,
  output logic                  overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DATA_W:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_q, rd_q;
  logic [LW-1:0]           level_q, level_d;
  logic                    new_q;
  logic                    empty_q, full_q, irq_q, ovr_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    rd_err_q;
  logic                    push, pop, wr_ok;

  assign push  = rx_new_data & ~new_q;
  assign pop   = rd_en & ~empty_q;
  // A full FIFO still accepts a word when a pop frees the slot the same cycle
  assign wr_ok = push & (~full_q | pop);

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      unique case ({wr_ok, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) begin
      mem[wr_q] <= {rx_frame_err, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      new_q     <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      new_q   <= rx_new_data;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LVL_FULL);
      irq_q   <= (irq_thresh != '0) && (level_d >= irq_thresh);
      if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        ovr_q <= 1'b0;
      end else begin
        if (wr_ok) wr_q <= wr_q + 1'b1;
        if (push && !wr_ok) ovr_q <= 1'b1;
        if (pop) begin
          rd_q      <= rd_q + 1'b1;
          rd_data_q <= mem[rd_q][DATA_W-1:0];
          rd_err_q  <= mem[rd_q][DATA_W];
        end
      end
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [23:0] cnt_q;
  logic        tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (flush || wr_ok || pop || empty_q) cnt_q <= '0;
      else if (cnt_q != 24'hFF_FFFF) cnt_q <= cnt_q + 24'd1;
      if (flush || pop) tmo_q <= 1'b0;
      else if (cnt_q == timeout_cycles && timeout_cycles != '0 && !empty_q)
        tmo_q <= 1'b1;
    end
  end

  assign timeout = tmo_q;
`endif

  assign rd_data      = rd_data_q;
  assign rd_frame_err = rd_err_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign level        = level_q;
  assign irq_level    = irq_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: capture, ordering, wrap, overrun, irq, flush, reset.
// Inputs driven and outputs sampled on the falling edge.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_data;
  logic        rx_new_data;
  logic        rx_frame_err;
  logic        flush;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_frame_err;
  logic        empty;
  logic        full;
  logic [4:0]  level;
  logic [4:0]  irq_thresh;
  logic        irq_level;
  logic        overrun;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [23:0] timeout_cycles;
  logic        timeout;
`endif

  int errs = 0;
  int nchk = 0;
  logic [15:0] d;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_new_data  (rx_new_data),
    .rx_frame_err (rx_frame_err),
    .flush        (flush),
    .rd_en        (rd_en),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .timeout_cycles (timeout_cycles),
    .timeout        (timeout),
`endif
    .rd_data      (rd_data),
    .rd_frame_err (rd_frame_err),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .irq_thresh   (irq_thresh),
    .irq_level    (irq_level),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] v, input logic e);
    rx_data      = v;
    rx_frame_err = e;
    rx_new_data  = 1'b1;
    tick();
    rx_new_data  = 1'b0;
    tick();
  endtask

  task automatic pop_word(output logic [15:0] v);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    v = rd_data;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rx_data = '0;
    rx_new_data = 1'b0;
    rx_frame_err = 1'b0;
    flush = 1'b0;
    rd_en = 1'b0;
    irq_thresh = '0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_cycles = '0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    chk("rst_irq", 32'(irq_level), 0);

    // held new_data pushes once
    rx_data = 16'h00A5;
    rx_new_data = 1'b1;
    repeat (5) tick();
    rx_new_data = 1'b0;
    tick();
    chk("hold_level", 32'(level), 1);
    pop_word(d);
    chk("hold_data", 32'(d), 32'h00A5);
    chk("hold_empty", 32'(empty), 1);

    // overflow
    for (int i = 1; i <= 16; i++) push_word(16'(i), 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 16);
    chk("fill_ovr", 32'(overrun), 0);
    push_word(16'h0011, 1'b0);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_level", 32'(level), 16);
    for (int i = 1; i <= 16; i++) begin
      pop_word(d);
      chk($sformatf("ovr_pop%0d", i), 32'(d), 32'(i));
    end
    chk("ovr_empty", 32'(empty), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    pop_word(d);
    chk("empty_pop_hold", 32'(d), 32'h0010);
    do_flush();
    chk("flush_ovr", 32'(overrun), 0);

    // wrap: offset pointers, fill, then push+pop while full
    for (int i = 0; i < 3; i++) push_word(16'h0200, 1'b0);
    for (int i = 0; i < 3; i++) pop_word(d);
    for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i), 1'b0);
    chk("wrap_full", 32'(full), 1);
    rx_data = 16'h0055;
    rx_new_data = 1'b1;
    rd_en = 1'b1;
    tick();
    rx_new_data = 1'b0;
    rd_en = 1'b0;
    chk("pp_data", 32'(rd_data), 32'h0100);
    chk("pp_level", 32'(level), 16);
    chk("pp_ovr", 32'(overrun), 0);
    tick();
    for (int i = 1; i < 16; i++) begin
      pop_word(d);
      chk($sformatf("wrap_pop%0d", i), 32'(d), 32'h0100 + 32'(i));
    end
    pop_word(d);
    chk("wrap_last", 32'(d), 32'h0055);
    chk("wrap_empty", 32'(empty), 1);

    // push+pop while empty: pop ignored
    rx_data = 16'h0777;
    rx_new_data = 1'b1;
    rd_en = 1'b1;
    tick();
    rx_new_data = 1'b0;
    rd_en = 1'b0;
    chk("pe_level", 32'(level), 1);
    chk("pe_rdata", 32'(rd_data), 32'h0055);
    tick();
    pop_word(d);
    chk("pe_pop", 32'(d), 32'h0777);

    // threshold interrupt
    irq_thresh = 5'd4;
    for (int i = 0; i < 3; i++) push_word(16'h0030 + 16'(i), 1'b0);
    chk("irq_3", 32'(irq_level), 0);
    push_word(16'h0033, 1'b0);
    chk("irq_4", 32'(irq_level), 1);
    pop_word(d);
    chk("irq_pop", 32'(irq_level), 0);
    irq_thresh = 5'd0;
    do_flush();
    chk("irq_off", 32'(irq_level), 0);

    // frame error tag
    push_word(16'h0BAD, 1'b1);
    pop_word(d);
    chk("ferr_data", 32'(d), 32'h0BAD);
    chk("ferr_tag", 32'(rd_frame_err), 1);
    push_word(16'h0C00, 1'b0);
    pop_word(d);
    chk("ferr_clr", 32'(rd_frame_err), 0);

    // flush beats a simultaneous push; held new_data does not re-push
    for (int i = 0; i < 17; i++) push_word(16'h0400 + 16'(i), 1'b1);
    chk("pre_flush_ovr", 32'(overrun), 1);
    rx_data = 16'h0999;
    rx_new_data = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    rx_new_data = 1'b0;
    tick();
    chk("flush_level", 32'(level), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovr2", 32'(overrun), 0);
    chk("flush_rdata", 32'(rd_data), 32'h0C00);

    // reset mid-operation
    push_word(16'h0A0A, 1'b0);
    push_word(16'h0B0B, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_rdata", 32'(rd_data), 0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_cycles = 24'd100;
    push_word(16'h0123, 1'b0);
    repeat (50) tick();
    chk("tmo_early", 32'(timeout), 0);
    begin
      int n = 0;
      while (timeout !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      chk("tmo_seen", 32'(timeout), 1);
      chk("tmo_window", 32'(n >= 40 && n <= 60), 1);
    end
    pop_word(d);
    chk("tmo_pop_clr", 32'(timeout), 0);
    chk("tmo_data", 32'(d), 32'h0123);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
